// File: rtl/axonerve_kvs_ctrl_chain.sv
// Run controller for a bank of datamover channels: accepts a host start, fans out
// per-channel start pulses, gathers completions and reports done with a busy-cycle count.
module axonerve_kvs_ctrl_chain #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned XFER_W = 32,
    parameter int unsigned CYC_W  = 48
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              ap_start,
    input  logic              ap_continue,
    input  logic [XFER_W-1:0] data_num,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic              ap_done,
    output logic [NUM_CH-1:0] ch_start,
    output logic [XFER_W-1:0] ch_xfer_size,
    output logic [CYC_W-1:0]  busy_cycles,
    output logic              err_zero_len
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        r_state;
    logic              r_ap_start;
    logic              r_idle;
    logic              r_ready;
    logic              r_done;
    logic [NUM_CH-1:0] r_ch_start;
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_done_ch;
    logic [XFER_W-1:0] r_xfer;
    logic [CYC_W-1:0]  r_busy;
    logic              r_err;

    logic [1:0]        w_state_d;
    logic              w_start_edge;
    logic              w_accept;
    logic              w_zero;
    logic [NUM_CH-1:0] w_done_acc;

    always_comb begin
        w_start_edge = ap_start & ~r_ap_start;
        w_accept     = (r_state == StIdle) && w_start_edge;
        w_zero       = (data_num == '0) || (ch_enable == '0);
        // Completions of channels not taking part in this run are masked off.
        w_done_acc   = r_done_ch | (ch_done & r_en);
        w_state_d    = r_state;
        case (r_state)
            StIdle:  if (w_start_edge) w_state_d = w_zero ? StDone : StRun;
            StRun:   if (w_done_acc == r_en) w_state_d = StDone;
            StDone:  if (ap_continue) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Sampled through reset so a start level held across reset release is not an edge.
    always_ff @(posedge ap_clk) begin
        r_ap_start <= ap_start;
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state    <= StIdle;
            r_idle     <= 1'b1;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_ch_start <= '0;
            r_en       <= '0;
            r_done_ch  <= '0;
            r_xfer     <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_idle     <= (w_state_d == StIdle);
            r_done     <= (w_state_d == StDone);
            r_ready    <= w_accept;
            r_ch_start <= (w_accept && !w_zero) ? ch_enable : '0;
            if (w_accept) begin
                r_err  <= w_zero;
                r_busy <= '0;
                if (!w_zero) begin
                    r_xfer    <= data_num;
                    r_en      <= ch_enable;
                    r_done_ch <= '0;
                end
            end else if (r_state == StRun) begin
                r_done_ch <= w_done_acc;
                if (r_busy != '1) r_busy <= r_busy + CYC_W'(1);
            end
        end
    end

    assign ap_idle      = r_idle;
    assign ap_ready     = r_ready;
    assign ap_done      = r_done;
    assign ch_start     = r_ch_start;
    assign ch_xfer_size = r_xfer;
    assign busy_cycles  = r_busy;
    assign err_zero_len = r_err;

endmodule

// File: tb/tb_axonerve_kvs_ctrl_chain.sv
// Scoreboard bench for axonerve_kvs_ctrl_chain: expected run results are queued at start
// and compared when ap_done rises; per-cycle handshake checks are made inline.
module tb_axonerve_kvs_ctrl_chain;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned XFER_W = 32;
    localparam int unsigned CYC_W  = 48;

    typedef struct {
        logic [XFER_W-1:0] xfer;
        logic              err;
        logic [CYC_W-1:0]  busy;
        logic [NUM_CH-1:0] chs;
        int                chs_cyc;
    } exp_t;

    logic              ap_clk = 1'b0;
    logic              areset;
    logic              ap_start;
    logic              ap_continue;
    logic [XFER_W-1:0] data_num;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] ch_done;
    logic              ap_idle;
    logic              ap_ready;
    logic              ap_done;
    logic [NUM_CH-1:0] ch_start;
    logic [XFER_W-1:0] ch_xfer_size;
    logic [CYC_W-1:0]  busy_cycles;
    logic              err_zero_len;

    axonerve_kvs_ctrl_chain #(
        .NUM_CH(NUM_CH),
        .XFER_W(XFER_W),
        .CYC_W (CYC_W)
    ) u_dut (
        .ap_clk      (ap_clk),
        .areset      (areset),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .data_num    (data_num),
        .ch_enable   (ch_enable),
        .ch_done     (ch_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ch_start    (ch_start),
        .ch_xfer_size(ch_xfer_size),
        .busy_cycles (busy_cycles),
        .err_zero_len(err_zero_len)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t              sb[$];
    logic [NUM_CH-1:0] sched [0:31];
    logic [XFER_W-1:0] last_xfer = '0;
    logic [CYC_W-1:0]  last_busy = '0;

    // Monitor accumulators
    logic [NUM_CH-1:0] acc_chs   = '0;
    int                n_chs     = 0;
    int                n_rdy     = 0;
    int                tot_chs   = 0;
    int                tot_rdy   = 0;
    logic              prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    always @(negedge ap_clk) begin
        exp_t e;
        if (areset) begin
            acc_chs = '0;
            n_chs   = 0;
            n_rdy   = 0;
        end else begin
            if (ch_start != '0) begin
                acc_chs = acc_chs | ch_start;
                n_chs++;
                tot_chs++;
            end
            if (ap_ready) begin
                n_rdy++;
                tot_rdy++;
            end
            if (ap_done && !prev_done) begin
                check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("sb_xfer", 64'(ch_xfer_size), 64'(e.xfer));
                    check_eq("sb_err", 64'(err_zero_len), 64'(e.err));
                    check_eq("sb_busy", 64'(busy_cycles), 64'(e.busy));
                    check_eq("sb_ch_start_mask", 64'(acc_chs), 64'(e.chs));
                    check_eq("sb_ch_start_cycles", 64'(n_chs), 64'(e.chs_cyc));
                    check_eq("sb_ready_pulses", 64'(n_rdy), 64'd1);
                end
                acc_chs = '0;
                n_chs   = 0;
                n_rdy   = 0;
            end
        end
        prev_done = ap_done;
    end

    task automatic clear_sched();
        for (int i = 0; i < 32; i++) sched[i] = '0;
    endtask

    // Accepted run; completion cycle derived from the done schedule and the enable mask.
    task automatic run_job(input logic [XFER_W-1:0] dn, input logic [NUM_CH-1:0] en,
                           input bit disturb);
        exp_t              e;
        int                last;
        logic [NUM_CH-1:0] acc;
        acc  = '0;
        last = 0;
        for (int c = 1; c < 32; c++) begin
            acc = acc | (sched[c] & en);
            if (acc == en && last == 0) last = c;
        end
        e.xfer    = dn;
        e.err     = 1'b0;
        e.busy    = CYC_W'(last);
        e.chs     = en;
        e.chs_cyc = 1;
        sb.push_back(e);
        last_xfer = dn;
        last_busy = CYC_W'(last);

        check_eq("idle_before_start", 64'(ap_idle), 64'd1);
        ap_start  = 1'b1;
        data_num  = dn;
        ch_enable = en;
        tick();
        check_eq("ready_pulse", 64'(ap_ready), 64'd1);
        check_eq("ch_start_mask", 64'(ch_start), 64'(en));
        check_eq("not_idle_run", 64'(ap_idle), 64'd0);
        check_eq("xfer_latched", 64'(ch_xfer_size), 64'(dn));
        ap_start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            ch_done = sched[c];
            if (disturb) begin
                case (c)
                    2: ap_start = 1'b1;
                    3: begin ap_start = 1'b0; ap_continue = 1'b1; end
                    4: begin ap_start = 1'b1; ap_continue = 1'b0; end
                    5: begin ap_start = 1'b0; ap_continue = 1'b1; end
                    default: ap_continue = 1'b0;
                endcase
            end
            tick();
            ch_done = '0;
            check_eq($sformatf("done_at_c%0d", c), 64'(ap_done), 64'(c == last));
            if (c == 1) begin
                check_eq("ch_start_one_cycle", 64'(ch_start), 64'd0);
                check_eq("ready_one_cycle", 64'(ap_ready), 64'd0);
            end
        end
        ap_start    = 1'b0;
        ap_continue = 1'b0;
    endtask

    task automatic reject_job(input logic [XFER_W-1:0] dn, input logic [NUM_CH-1:0] en);
        exp_t e;
        e.xfer    = last_xfer;
        e.err     = 1'b1;
        e.busy    = '0;
        e.chs     = '0;
        e.chs_cyc = 0;
        sb.push_back(e);
        last_busy = '0;
        ap_start  = 1'b1;
        data_num  = dn;
        ch_enable = en;
        tick();
        check_eq("rej_ready", 64'(ap_ready), 64'd1);
        check_eq("rej_no_ch_start", 64'(ch_start), 64'd0);
        check_eq("rej_err", 64'(err_zero_len), 64'd1);
        check_eq("rej_done", 64'(ap_done), 64'd1);
        check_eq("rej_xfer_hold", 64'(ch_xfer_size), 64'(last_xfer));
        ap_start = 1'b0;
    endtask

    // Hold in DONE for a few cycles (with stray ch_done), then acknowledge.
    task automatic finish_job(input int hold);
        for (int i = 0; i < hold; i++) begin
            ch_done = (i == 0) ? '1 : '0;
            tick();
            check_eq("done_held", 64'(ap_done), 64'd1);
        end
        ch_done     = '0;
        ap_continue = 1'b1;
        tick();
        ap_continue = 1'b0;
        check_eq("done_cleared", 64'(ap_done), 64'd0);
        check_eq("idle_after_continue", 64'(ap_idle), 64'd1);
        check_eq("busy_hold_idle", 64'(busy_cycles), 64'(last_busy));
        check_eq("xfer_hold_idle", 64'(ch_xfer_size), 64'(last_xfer));
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_idle"}, 64'(ap_idle), 64'd1);
        check_eq({pfx, "_ready"}, 64'(ap_ready), 64'd0);
        check_eq({pfx, "_done"}, 64'(ap_done), 64'd0);
        check_eq({pfx, "_ch_start"}, 64'(ch_start), 64'd0);
        check_eq({pfx, "_xfer"}, 64'(ch_xfer_size), 64'd0);
        check_eq({pfx, "_busy"}, 64'(busy_cycles), 64'd0);
        check_eq({pfx, "_err"}, 64'(err_zero_len), 64'd0);
    endtask

    initial begin
        int snap_chs;
        int snap_rdy;
        areset      = 1'b1;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        data_num    = '0;
        ch_enable   = '0;
        ch_done     = '0;
        clear_sched();
        repeat (3) tick();
        check_reset_values("rst");
        areset = 1'b0;
        tick();

        // Stray completions in IDLE must not leak into the next run.
        ch_done = '1;
        tick();
        ch_done = '0;

        // Four channels, done at 10, 12, 12, 20 with a repeated ch0 done.
        clear_sched();
        sched[10] = 4'b0001;
        sched[12] = 4'b0110;
        sched[15] = 4'b0001;
        sched[20] = 4'b1000;
        run_job(32'd4096, 4'b1111, 1'b0);
        finish_job(3);

        // Partial mask: disabled channels' completions are ignored.
        clear_sched();
        sched[2] = 4'b1010;
        sched[4] = 4'b1010;
        sched[6] = 4'b0001;
        sched[9] = 4'b0100;
        run_job(32'd256, 4'b0101, 1'b0);
        finish_job(2);

        reject_job(32'd0, 4'b1111);
        finish_job(2);
        reject_job(32'd8, 4'b0000);
        finish_job(1);

        // Start edges and ap_continue during RUN are ignored.
        clear_sched();
        sched[3] = 4'b0011;
        sched[7] = 4'b1100;
        run_job(32'd1000, 4'b1111, 1'b1);
        finish_job(5);

        // Completion in the first RUN cycle.
        clear_sched();
        sched[1] = 4'b1111;
        run_job(32'd64, 4'b1111, 1'b0);
        finish_job(1);

        // Reset three cycles into RUN with ap_start held high.
        ap_start  = 1'b1;
        data_num  = 32'd100;
        ch_enable = 4'b1111;
        tick();
        check_eq("abort_ready", 64'(ap_ready), 64'd1);
        tick();
        tick();
        areset = 1'b1;
        tick();
        check_reset_values("abort");
        last_xfer = '0;
        last_busy = '0;
        tick();
        areset = 1'b0;
        snap_chs = tot_chs;
        snap_rdy = tot_rdy;
        repeat (6) tick();
        check_eq("abort_still_idle", 64'(ap_idle), 64'd1);
        check_eq("abort_no_done", 64'(ap_done), 64'd0);
        check_eq("abort_no_ch_start", 64'(tot_chs), 64'(snap_chs));
        check_eq("abort_no_ready", 64'(tot_rdy), 64'(snap_rdy));
        ap_start = 1'b0;
        tick();

        clear_sched();
        sched[2] = 4'b0010;
        sched[5] = 4'b0100;
        run_job(32'd512, 4'b0110, 1'b0);
        finish_job(1);

        repeat (2) tick();
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axonerve_kvs_ctrl_chain.md
AXONERVE_KVS_CTRL_CHAIN -- requirements
Module: axonerve_kvs_ctrl_chain

Interface
REQ-001 Parameter: NUM_CH, default 4, number of datamover channels controlled (1..16).
REQ-002 Parameter: XFER_W, default 32, width of transfer-size field.
REQ-003 Parameter: CYC_W, default 48, width of busy-cycle counter.
REQ-004 Port: ap_clk  in  1  clock; all logic rising-edge.
REQ-005 Port: areset  in  1  reset, synchronous, active-high.
REQ-006 Port: ap_start  in  1  host start level; rising edge requests a run.
REQ-007 Port: ap_continue  in  1  host acknowledge of ap_done.
REQ-008 Port: data_num  in  XFER_W  transfer size in bytes for this run.
REQ-009 Port: ch_enable  in  NUM_CH  channel participation mask for this run.
REQ-010 Port: ch_done  in  NUM_CH  per-channel completion pulses.
REQ-011 Port: ap_idle  out  1  block idle.
REQ-012 Port: ap_ready  out  1  one-cycle pulse, run accepted.
REQ-013 Port: ap_done  out  1  run complete, held until ap_continue.
REQ-014 Port: ch_start  out  NUM_CH  one-cycle start pulses to enabled channels.
REQ-015 Port: ch_xfer_size  out  XFER_W  transfer size latched at run start.
REQ-016 Port: busy_cycles  out  CYC_W  cycles spent in RUN for last/current run.
REQ-017 Port: err_zero_len  out  1  last run rejected (data_num==0 or ch_enable==0).

Function
REQ-018 Start edge = ap_start & ~ap_start_r, ap_start_r registered every cycle including during reset.
REQ-019 States IDLE, RUN, DONE; ap_idle=1 only in IDLE, registered.
REQ-020 IDLE + start edge, data_num!=0 and ch_enable!=0: latch data_num->ch_xfer_size, ch_enable->en_r, clear done_r, busy_cycles, err_zero_len; next cycle ch_start=en_r for exactly one cycle, ap_ready=1 one cycle, state RUN.
REQ-021 IDLE + start edge, data_num==0 or ch_enable==0: no ch_start, ap_ready=1 one cycle, err_zero_len=1, busy_cycles=0, state DONE.
REQ-022 Start edges outside IDLE discarded; no queuing.
REQ-023 RUN: done_r <= done_r | (ch_done & en_r) each cycle; ch_done bits of disabled channels ignored.
REQ-024 RUN -> DONE in the cycle where (done_r | (ch_done & en_r)) == en_r; ap_done=1 from the next cycle.
REQ-025 Repeated ch_done on an already-done channel has no effect.
REQ-026 ch_done in IDLE or DONE ignored and not carried into the next run.
REQ-027 busy_cycles increments by 1 each cycle in RUN, saturates at all-ones, holds value in DONE and IDLE.
REQ-028 DONE: ap_done held 1 until ap_continue sampled 1; then state IDLE, ap_done=0 next cycle.
REQ-029 ap_continue outside DONE ignored.
REQ-030 ch_xfer_size and err_zero_len hold until the next accepted start.

Reset
REQ-031 areset: state IDLE, ap_idle=1, ap_ready=0, ap_done=0, ch_start=0, ch_xfer_size=0, busy_cycles=0, err_zero_len=0, done_r=0, en_r=0.
REQ-032 areset mid-RUN or mid-DONE aborts the run; no ch_start or ap_done pulse emitted after reset deasserts.
REQ-033 ap_start held high through reset release is not a start edge.

Verification
REQ-034 NUM_CH=4, data_num=4096, ch_enable=4'b1111, ch_done on ch0..3 at cycles 10,12,12,20 -> ch_start=4'b1111 one cycle, ch_xfer_size=4096, ap_done high the cycle after ch3 done, busy_cycles=count of RUN cycles.
REQ-035 ch_enable=4'b0101, ch_done pulses on ch1/ch3 only -> stays RUN; ch0+ch2 done -> DONE; ch_start=4'b0101.
REQ-036 data_num=0 -> ap_ready pulse, err_zero_len=1, ap_done=1, ch_start never asserted; ap_continue -> IDLE.
REQ-037 second ap_start edge during RUN and ap_continue pulses during RUN -> no effect; ap_done held 5 cycles until ap_continue=1, then IDLE and next start accepted.
REQ-038 areset asserted 3 cycles into RUN with ap_start high -> all outputs reset values, no further ch_start, no run starts until ap_start falls and rises again.
